hp_burst_sequencer: RTL

Sequences 4 KB AXI bursts on the HP master port between a host-programmed start and end address, in write or read mode. Sits between the host-register kernel and the HP AXI master: the kernel supplies the address range, mode and write-data stream; this block drives AW/AR, gates W, and accepts B/R. It limits outstanding transactions and reports completion and response errors.

---
 rtl/hp_burst_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hp_burst_sequencer.sv
// Issues BURST_BYTES-sized AXI4 INCR bursts across [start_addr, end_addr) in write or read mode.
// Optional macro HP_SEQ_ERR_STOP_EN: the first non-OKAY response stops further address issue.
module hp_burst_sequencer #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned BURST_BYTES     = 4096,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    mode,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   end_addr,
  output logic [1:0]              state,
  output logic                    err,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [DATA_WIDTH-1:0]   rbeat_data_o,
  output logic                    rbeat_valid_o,
  output logic [ADDR_WIDTH-1:0]   hp_awaddr,
  output logic [7:0]              hp_awlen,
  output logic [2:0]              hp_awsize,
  output logic [1:0]              hp_awburst,
  output logic                    hp_awvalid,
  input  logic                    hp_awready,
  output logic [DATA_WIDTH-1:0]   hp_wdata,
  output logic [DATA_WIDTH/8-1:0] hp_wstrb,
  output logic                    hp_wlast,
  output logic                    hp_wvalid,
  input  logic                    hp_wready,
  input  logic [1:0]              hp_bresp,
  input  logic                    hp_bvalid,
  output logic                    hp_bready,
  output logic [ADDR_WIDTH-1:0]   hp_araddr,
  output logic [7:0]              hp_arlen,
  output logic [2:0]              hp_arsize,
  output logic [1:0]              hp_arburst,
  output logic                    hp_arvalid,
  input  logic                    hp_arready,
  input  logic [DATA_WIDTH-1:0]   hp_rdata,
  input  logic [1:0]              hp_rresp,
  input  logic                    hp_rlast,
  input  logic                    hp_rvalid,
  output logic                    hp_rready
);

  localparam int unsigned BeatBytes = DATA_WIDTH / 8;
  localparam int unsigned Beats     = BURST_BYTES / BeatBytes;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] Step    = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(BURST_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} st_e;

  st_e                   st_q;
  logic                  mode_q, err_q, aw_valid_q, ar_valid_q, rbeat_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q, cur_q, end_q;
  logic [CntW-1:0]       out_q, out_nxt, wpend_q, wpend_nxt;
  logic [BeatW-1:0]      wbeat_q;
  logic [DATA_WIDTH-1:0] rbeat_data_q;

  logic [ADDR_WIDTH-1:0] start_al, end_al;
  logic aw_hs, ar_hs, a_hs, b_done, r_hs, r_done, a_done, w_hs, w_done;
  logic err_evt, stop, a_free, can_load, active;

  assign start_al = start_addr & ~OffMask;
  assign end_al   = end_addr & ~OffMask;
  assign active   = (st_q == StRun) || (st_q == StDrain);

  assign aw_hs   = aw_valid_q & hp_awready;
  assign ar_hs   = ar_valid_q & hp_arready;
  assign a_hs    = aw_hs | ar_hs;
  assign b_done  = hp_bvalid & hp_bready & ~mode_q;
  assign r_hs    = hp_rvalid & hp_rready;
  assign r_done  = r_hs & hp_rlast & mode_q;
  assign a_done  = b_done | r_done;
  assign w_hs    = hp_wvalid & hp_wready;
  assign w_done  = w_hs & hp_wlast;
  assign err_evt = (b_done && (hp_bresp != 2'b00)) || (r_hs && mode_q && (hp_rresp != 2'b00));

`ifdef HP_SEQ_ERR_STOP_EN
  assign stop = err_q | err_evt;
`else
  assign stop = 1'b0;
`endif

  // A new address may be loaded once the address slot frees and credit remains after this cycle.
  assign a_free   = ~(aw_valid_q | ar_valid_q) | a_hs;
  assign can_load = a_free && (cur_q < end_q) && !stop && (out_nxt < CntW'(MAX_OUTSTANDING));

  always_comb begin
    out_nxt = out_q;
    if (a_hs && !a_done) out_nxt = out_q + 1'b1;
    else if (!a_hs && a_done) out_nxt = out_q - 1'b1;
    wpend_nxt = wpend_q;
    if (aw_hs && !w_done) wpend_nxt = wpend_q + 1'b1;
    else if (!aw_hs && w_done) wpend_nxt = wpend_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q          <= StIdle;
      mode_q        <= 1'b0;
      err_q         <= 1'b0;
      aw_valid_q    <= 1'b0;
      ar_valid_q    <= 1'b0;
      addr_q        <= '0;
      cur_q         <= '0;
      end_q         <= '0;
      out_q         <= '0;
      wpend_q       <= '0;
      wbeat_q       <= '0;
      rbeat_valid_q <= 1'b0;
      rbeat_data_q  <= '0;
    end else begin
      out_q         <= out_nxt;
      wpend_q       <= wpend_nxt;
      rbeat_valid_q <= r_hs;
      if (r_hs) rbeat_data_q <= hp_rdata;
      if (w_hs) wbeat_q <= hp_wlast ? '0 : wbeat_q + 1'b1;
      if (err_evt) err_q <= 1'b1;
      if (a_hs) begin
        aw_valid_q <= 1'b0;
        ar_valid_q <= 1'b0;
      end
      case (st_q)
        StIdle, StDone: begin
          if (start) begin
            st_q    <= StRun;
            mode_q  <= mode;
            end_q   <= end_al;
            err_q   <= 1'b0;
            out_q   <= '0;
            wpend_q <= '0;
            wbeat_q <= '0;
            addr_q  <= start_al;
            if (start_al < end_al) begin
              aw_valid_q <= ~mode;
              ar_valid_q <= mode;
              cur_q      <= start_al + Step;
            end else begin
              cur_q <= start_al;
            end
          end else if (clear && (st_q == StDone)) begin
            st_q <= StIdle;
          end
        end
        StRun: begin
          if (can_load) begin
            addr_q     <= cur_q;
            aw_valid_q <= ~mode_q;
            ar_valid_q <= mode_q;
            cur_q      <= cur_q + Step;
          end else if (a_free && ((cur_q >= end_q) || stop)) begin
            st_q <= StDrain;
          end
        end
        StDrain: begin
          if ((out_nxt == '0) && (wpend_nxt == '0)) st_q <= StDone;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (st_q)
      StRun, StDrain: state = 2'd1;
      StDone:         state = 2'd2;
      default:        state = 2'd0;
    endcase
  end

  assign err           = err_q;
  assign hp_awaddr     = addr_q;
  assign hp_araddr     = addr_q;
  assign hp_awvalid    = aw_valid_q;
  assign hp_arvalid    = ar_valid_q;
  assign hp_awlen      = 8'(Beats - 1);
  assign hp_arlen      = 8'(Beats - 1);
  assign hp_awsize     = 3'($clog2(BeatBytes));
  assign hp_arsize     = 3'($clog2(BeatBytes));
  assign hp_awburst    = 2'b01;
  assign hp_arburst    = 2'b01;
  assign hp_wdata      = wdata_i;
  assign hp_wstrb      = '1;
  assign hp_wvalid     = wvalid_i & (wpend_q != '0);
  assign wready_o      = hp_wready & (wpend_q != '0);
  assign hp_wlast      = (wpend_q != '0) && (wbeat_q == BeatW'(Beats - 1));
  assign hp_bready     = active;
  assign hp_rready     = active;
  assign rbeat_valid_o = rbeat_valid_q;
  assign rbeat_data_o  = rbeat_data_q;

endmodule
